// File: rtl/crc_pkg.sv
// Shared CRC definitions for the generator and checker paths: CRC-16/ARC defaults,
// trailer word-count helper and a generic bit-reversal function.
package crc_pkg;

  localparam logic [15:0] CRC16_ARC_POLY = 16'h8005;
  localparam logic [15:0] CRC16_ARC_INIT = 16'h0000;
  localparam int unsigned MAX_WIDTH      = 64;

  // Number of stream words that make up one CRC trailer.
  function automatic int unsigned crc_words(input int unsigned crc_w, input int unsigned dat_w);
    return crc_w / dat_w;
  endfunction

  // Reverses the low w bits of v; upper bits of the result are zero.
  function automatic logic [MAX_WIDTH-1:0] reverse_bits(input logic [MAX_WIDTH-1:0] v,
                                                        input int unsigned w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[6'(i)] = v[6'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_calculator.sv
// Combinational one-word CRC step, MSB-first (normal polynomial form).
module crc_calculator #(
  parameter int                  DATAWIDTH  = 8,
  parameter int                  CRCWIDTH   = 16,
  parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 16'h8005
) (
  input  logic [DATAWIDTH-1:0] i_dat,
  input  logic [CRCWIDTH-1:0]  i_crc,
  output logic [CRCWIDTH-1:0]  o_crc
);

  always_comb begin
    logic fb;
    fb    = 1'b0;
    o_crc = i_crc;
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      fb    = o_crc[CRCWIDTH-1] ^ i_dat[i];
      o_crc = {o_crc[CRCWIDTH-2:0], 1'b0} ^ (fb ? POLYNOMIAL : '0);
    end
  end

endmodule

// File: rtl/crc_stream_checker.sv
// Receive-side CRC checker: delays the stream by one trailer length, strips the trailer,
// and flags a non-zero CRC residue on the last payload beat.
module crc_stream_checker
  import crc_pkg::*;
#(
  parameter int                  DATAWIDTH  = 8,
  parameter int                  CRCWIDTH   = 16,
  parameter logic [CRCWIDTH-1:0] POLYNOMIAL = CRC16_ARC_POLY,
  parameter logic [CRCWIDTH-1:0] INIT       = CRC16_ARC_INIT,
  parameter bit                  REFLECT    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] i_dat,
  input  logic                 i_val,
  input  logic                 i_eop,
  output logic                 o_rdy,
  output logic [DATAWIDTH-1:0] o_dat,
  output logic                 o_val,
  output logic                 o_eop,
  output logic                 o_err,
  input  logic                 i_rdy,
  output logic                 o_runt
);

  localparam int              CW     = int'(crc_words(CRCWIDTH, DATAWIDTH));
  localparam int              CNTW   = $clog2(CW + 1);
  localparam logic [CNTW-1:0] CW_CNT = CNTW'(CW);

  generate
    if ((CRCWIDTH % DATAWIDTH) != 0) begin : g_width_check
      $error("crc_stream_checker: CRCWIDTH must be a multiple of DATAWIDTH");
    end
  endgenerate

  logic [DATAWIDTH-1:0] r_buf [CW];
  logic [CNTW-1:0]      r_cnt;
  logic [CRCWIDTH-1:0]  r_crc;
  logic                 r_runt;
  logic [CRCWIDTH-1:0]  w_crc_nxt;
  logic [DATAWIDTH-1:0] w_crc_in;
  logic                 w_full;
  logic                 w_acc;

  genvar gi;
  generate
    for (gi = 0; gi < DATAWIDTH; gi++) begin : g_reflect
      assign w_crc_in[gi] = REFLECT ? i_dat[DATAWIDTH-1-gi] : i_dat[gi];
    end
  endgenerate

  crc_calculator #(
    .DATAWIDTH (DATAWIDTH),
    .CRCWIDTH  (CRCWIDTH),
    .POLYNOMIAL(POLYNOMIAL)
  ) u_crc (
    .i_dat(w_crc_in),
    .i_crc(r_crc),
    .o_crc(w_crc_nxt)
  );

  // Once the delay line holds a full trailer, the sink and source move in lockstep.
  assign w_full = (r_cnt == CW_CNT);
  assign o_rdy  = w_full ? i_rdy : 1'b1;
  assign w_acc  = i_val & o_rdy;
  assign o_val  = w_full & i_val;
  assign o_dat  = o_val ? r_buf[0] : '0;
  assign o_eop  = o_val & i_eop;
  assign o_err  = o_eop & (w_crc_nxt != '0);
  assign o_runt = r_runt;

  // Contents are don't-care after a frame ends, so the shift runs on every accepted word.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int k = 0; k < CW - 1; k++) r_buf[k] <= r_buf[k+1];
      r_buf[CW-1] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_crc  <= INIT;
      r_runt <= 1'b0;
    end else begin
      r_runt <= 1'b0;
      if (w_acc) begin
        if (i_eop) begin
          r_cnt  <= '0;
          r_crc  <= INIT;
          r_runt <= !w_full;
        end else begin
          r_crc <= w_crc_nxt;
          if (!w_full) r_cnt <= r_cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_checker.sv
// Scoreboard bench for crc_stream_checker with CRC-16/ARC defaults (two-word trailer).
module tb_crc_stream_checker;

  localparam int CW = 2;

  typedef struct packed {
    logic [7:0] dat;
    logic       eop;
    logic       err;
  } beat_t;

  logic       clk;
  logic       reset;
  logic [7:0] i_dat;
  logic       i_val;
  logic       i_eop;
  logic       o_rdy;
  logic [7:0] o_dat;
  logic       o_val;
  logic       o_eop;
  logic       o_err;
  logic       i_rdy;
  logic       o_runt;

  crc_stream_checker dut (
    .clk   (clk),
    .reset (reset),
    .i_dat (i_dat),
    .i_val (i_val),
    .i_eop (i_eop),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_val (o_val),
    .o_eop (o_eop),
    .o_err (o_err),
    .i_rdy (i_rdy),
    .o_runt(o_runt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  beat_t      exp_q[$];
  logic [7:0] frame_q[$];
  int         beats   = 0;
  int         runts   = 0;
  int         cyc     = 0;
  int         m_cnt   = 0;
  bit         exp_runt = 1'b0;
  bit         next_runt;
  bit         lat_arm  = 1'b0;
  int         lat_start = -1;
  beat_t      got_b;
  beat_t      exp_b;
  int         base;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pushes the expected source beats for frame_q, then drives it word by word.
  task automatic send_frame(input int gap_pct, input bit tog, input bit exp_err, input bit partial);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n - CW; i++) begin
      beat_t b;
      b.dat = frame_q[i];
      b.eop = !partial && (i == n - CW - 1);
      b.err = b.eop && exp_err;
      exp_q.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      bit done;
      int guard;
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        i_rdy = tog ? ~i_rdy : 1'b1;
        i_val = ($urandom_range(99) >= gap_pct);
        i_dat = frame_q[i];
        i_eop = !partial && (i == n - 1);
        @(negedge clk);
        done = i_val && o_rdy;
        @(posedge clk);
        #1;
        guard++;
        if (!done && guard > 200) begin
          check_eq("sink_stall_timeout", 32'(guard), 32'd200);
          done = 1'b1;
        end
      end
    end
    i_val = 1'b0;
    i_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    i_val = 1'b0;
    i_eop = 1'b0;
    i_rdy = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_good();
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3D, 8'hBB};
  endtask

  task automatic load_bad();
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3D, 8'hBA};
  endtask

  // Monitor: bench-side model of fill count, ready, valid and runt timing, plus scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check_eq("rst_val", o_val, 1'b0);
      check_eq("rst_rdy", o_rdy, 1'b1);
      check_eq("rst_runt", o_runt, 1'b0);
      m_cnt    = 0;
      exp_runt = 1'b0;
    end else begin
      check_eq("runt", o_runt, exp_runt);
      if (o_runt) runts++;
      check_eq("rdy", o_rdy, !(m_cnt == CW && !i_rdy));
      check_eq("val", o_val, i_val && m_cnt == CW);
      if (o_val && i_rdy) begin
        got_b = '{dat: o_dat, eop: o_eop, err: o_err};
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 32'(got_b), 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          check_eq("beat", 32'(got_b), 32'(exp_b));
          beats++;
        end
        if (lat_arm) begin
          check_eq("latency", 32'(cyc - lat_start), 32'(CW));
          lat_arm = 1'b0;
        end
      end else if (!o_val) begin
        check_eq("idle_zero", {o_dat, o_eop, o_err}, 10'd0);
      end
      next_runt = 1'b0;
      if (i_val && o_rdy) begin
        if (lat_arm && lat_start < 0) lat_start = cyc;
        if (i_eop) begin
          next_runt = (m_cnt < CW);
          m_cnt     = 0;
        end else if (m_cnt < CW) begin
          m_cnt++;
        end
      end
      exp_runt = next_runt;
    end
  end

  initial begin
    reset = 1'b0;
    i_dat = '0;
    i_val = 1'b0;
    i_eop = 1'b0;
    i_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // 1: good frame, full rate, latency check
    base = beats;
    lat_start = -1;
    lat_arm = 1'b1;
    load_good();
    send_frame(0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("s1_beats", 32'(beats - base), 32'd9);

    // 2: corrupted trailer
    base = beats;
    load_bad();
    send_frame(0, 1'b0, 1'b1, 1'b0);
    idle(3);
    check_eq("s2_beats", 32'(beats - base), 32'd9);

    // 3: runts then a good frame
    base = runts;
    frame_q = '{8'hAA};
    send_frame(0, 1'b0, 1'b0, 1'b0);
    frame_q = '{8'hAA, 8'hBB};
    send_frame(0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("s3_runts", 32'(runts - base), 32'd2);
    base = beats;
    load_good();
    send_frame(0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("s3_beats", 32'(beats - base), 32'd9);

    // 4: toggling backpressure and random valid gaps
    base = beats;
    load_good();
    send_frame(30, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_eq("s4_beats", 32'(beats - base), 32'd9);

    // 5: reset after 35; the three beats already cut through before reset are legitimate
    base = beats;
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    send_frame(0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    load_good();
    send_frame(0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("s5_beats", 32'(beats - base), 32'd12);

    // 6: three back-to-back frames
    base = beats;
    load_good();
    send_frame(0, 1'b0, 1'b0, 1'b0);
    load_bad();
    send_frame(0, 1'b0, 1'b1, 1'b0);
    load_good();
    send_frame(0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("s6_beats", 32'(beats - base), 32'd27);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
